// File: rtl/shift_divider_seq.sv
// rtl/shift_divider_seq.sv - sequential signed restoring divider, one quotient bit per clock
module shift_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             sign_dd;
    logic             sign_dv;
    logic             dbz_pend;
    logic             ovf_pend;
    logic [WIDTH-1:0] dd_mag;     // dividend magnitude; quotient bits shift in from the right
    logic [WIDTH-1:0] dv_mag;
    logic [WIDTH:0]   rem;        // one extra bit so the trial subtraction sign is visible
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;
    logic             start_ovf;

    // Operand magnitudes, one restoring step, and sign application of the final magnitudes
    always_comb begin
        dividend_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        shifted      = {rem[WIDTH-1:0], dd_mag[WIDTH-1]};
        trial        = shifted - {1'b0, dv_mag};
        q_signed     = (sign_dd ^ sign_dv) ? (~dd_mag + 1'b1) : dd_mag;
        r_signed     = sign_dd ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        // most-negative / -1 is the only pair whose true quotient does not fit
        start_ovf    = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
    end

    // Control FSM, datapath iteration and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            sign_dd     <= 1'b0;
            sign_dv     <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            dd_mag      <= '0;
            dv_mag      <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_dd  <= dividend[WIDTH-1];
                        sign_dv  <= divisor[WIDTH-1];
                        dd_mag   <= dividend_abs;
                        dv_mag   <= divisor_abs;
                        dbz_pend <= (divisor == '0);
                        ovf_pend <= start_ovf;
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt != CW'(WIDTH)) begin
                        if (!trial[WIDTH]) begin
                            rem    <= trial;
                            dd_mag <= {dd_mag[WIDTH-2:0], 1'b1};
                        end else begin
                            rem    <= shifted;
                            dd_mag <= {dd_mag[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        // a zero divisor leaves the dividend magnitude in rem, so r_signed is the dividend
                        quotient    <= dbz_pend ? {WIDTH{1'b1}} : q_signed;
                        remainder   <= r_signed;
                        div_by_zero <= dbz_pend;
                        overflow    <= ovf_pend;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_divider_seq.sv
// tb/tb_shift_divider_seq.sv - self-checking bench for shift_divider_seq
module tb_shift_divider_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int ovf;
    } vec_t;

    shift_divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        return v & ((1 << W) - 1);
    endfunction

    // Truncating signed division with the zero-divisor and overflow rules
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dbz, output int ovf);
        dbz = 0;
        ovf = 0;
        if (b == 0) begin
            q   = -1;
            r   = a;
            dbz = 1;
        end else if (a == -(1 << (W - 1)) && b == -1) begin
            q   = a;
            r   = 0;
            ovf = 1;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one operation from IDLE or DONE (called #1 after an edge) and check its result
    task automatic do_op(input int a, input int b, input int eq, input int er,
                         input int edbz, input int eovf, input string tag);
        int n;
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " busy_after_start"}, int'(busy), 1);
        check({tag, " done_after_start"}, int'(done), 0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, " latency"}, n, 5);
        check({tag, " busy_at_done"}, int'(busy), 0);
        check({tag, " quotient"}, int'(quotient), wrap(eq));
        check({tag, " remainder"}, int'(remainder), wrap(er));
        check({tag, " div_by_zero"}, int'(div_by_zero), edbz);
        check({tag, " overflow"}, int'(overflow), eovf);
    endtask

    initial begin
        vec_t tbl[6];
        int q, r, dbz, ovf, n, a, b;
        bit seen;

        tbl[0] = '{a:  7, b:  2, q:  3, r:  1, dbz: 0, ovf: 0};
        tbl[1] = '{a: -7, b:  2, q: -3, r: -1, dbz: 0, ovf: 0};
        tbl[2] = '{a:  7, b: -3, q: -2, r:  1, dbz: 0, ovf: 0};
        tbl[3] = '{a: -6, b: -2, q:  3, r:  0, dbz: 0, ovf: 0};
        tbl[4] = '{a: -8, b: -1, q: -8, r:  0, dbz: 0, ovf: 1};
        tbl[5] = '{a:  5, b:  0, q: -1, r:  5, dbz: 1, ovf: 0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset flags", int'({div_by_zero, overflow}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, back-to-back
        for (int i = 0; i < 6; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf,
                  $sformatf("table[%0d]", i));
        @(posedge clk);
        #1;
        check("table single done pulse", int'(done), 0);

        // start while busy is ignored: 6/4 with 3/1 pulsed before the second CALC edge
        dividend = 4'd6;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        dividend = 4'd3;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("ignored_start latency", n, 5);
        check("ignored_start quotient", int'(quotient), 1);
        check("ignored_start remainder", int'(remainder), 2);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done || busy) seen = 1'b1;
        end
        check("ignored_start no second op", int'(seen), 0);

        // Asynchronous reset in the middle of CALC
        dividend = 4'd7;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset quotient", int'(quotient), 0);
        check("midreset remainder", int'(remainder), 0);
        check("midreset flags", int'({div_by_zero, overflow}), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(7, 7, 1, 0, 0, 0, "after_reset 7/7");

        // Exhaustive sweep with starts issued in the DONE cycle
        for (int i = -(1 << (W - 1)); i < (1 << (W - 1)); i++) begin
            for (int j = -(1 << (W - 1)); j < (1 << (W - 1)); j++) begin
                model(i, j, q, r, dbz, ovf);
                do_op(i, j, q, r, dbz, ovf, $sformatf("sweep %0d/%0d", i, j));
            end
        end

        // Randomized operands
        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            b = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
            model(a, b, q, r, dbz, ovf);
            do_op(a, b, q, r, dbz, ovf, $sformatf("rand %0d/%0d", a, b));
        end

        @(posedge clk);
        #1;
        check("final idle done", int'(done), 0);
        check("final idle busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
